next_pc_unit: RTL
=================

Name: next_pc_unit

Overview:
Parametrised successor to the combinational jump-address concatenator. Holds the architectural PC register and computes the next PC for sequential, branch, jump and jump-register flow. Adds a return-address stack (RAS) that checks `jr` return predictions. Sits at the head of the fetch path: drives instruction-memory address and feeds `link_addr` to the register-file write mux.

Parameters:
ADDR_W, 32, PC width in bits; must be >= 28.
RESET_PC, 32'h0000_0000, PC value loaded on reset; truncated to ADDR_W.
RAS_DEPTH, 4, return-address stack entries; power of two, >= 2.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  1 = hold PC and RAS this cycle
pc_sel  in  2  00 SEQ, 01 BR, 10 J, 11 JR
branch_taken  in  1  branch condition result; used only when pc_sel=BR
imm16  in  16  branch offset (instruction[15:0])
jidx  in  26  jump index (instruction[25:0])
rs_val  in  ADDR_W  jump-register target
link  in  1  jal/jalr: push return address
ret  in  1  jr $ra: pop RAS and compare
pc  out  ADDR_W  current PC, registered
pc_plus4  out  ADDR_W  pc+4, combinational
link_addr  out  ADDR_W  return address (= pc_plus4)
ras_top  out  ADDR_W  top-of-stack entry; 0 when empty
ras_empty  out  1  RAS holds no entries
ras_mismatch  out  1  registered one-cycle pulse: return prediction wrong or RAS empty
addr_err  out  1  registered one-cycle pulse: misaligned JR target

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; RAS count=0, write pointer=0, all entries 0.
  - ras_mismatch=0, addr_err=0, ras_empty=1, ras_top=0.
- Update rule:
  - Every rising edge with stall=0: pc <= next_pc.
  - stall=1: pc, RAS and pointers hold; ras_mismatch and addr_err drive 0.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- next_pc by pc_sel:
  - SEQ: pc+4.
  - BR: branch_taken ? pc+4+(sign_extend(imm16)<<2) : pc+4.
  - J: {pc_plus4[ADDR_W-1:28], jidx, 2'b00}.
  - JR: rs_val.
- JR with rs_val[1:0] != 0:
  - pc holds; addr_err=1 next cycle.
  - No push or pop; ras_mismatch=0.
- Latency: next_pc is combinational; pc updates 1 cycle after the select. No bubbles; single-cycle core.
- RAS push: link=1, not stalled, pc_sel in {J, JR}.
  - Write link_addr at the write pointer; pointer++ mod RAS_DEPTH; count = min(count+1, RAS_DEPTH).
  - Full: the oldest entry is overwritten (circular); no error.
- RAS pop: ret=1, not stalled, pc_sel=JR, target aligned.
  - Non-empty: compare rs_val with ras_top. ras_mismatch=1 next cycle iff they differ. Pointer--, count--.
  - Empty: no pointer change; ras_mismatch=1.
- Simultaneous push and pop (jalr $ra):
  - Non-empty: top entry is replaced with link_addr; count unchanged. The mismatch compare still uses the old top.
  - Empty: push only; ras_mismatch=1.
- link/ret with pc_sel in {SEQ, BR}: ignored; no RAS change.
- The RAS is advisory only. pc always follows rs_val on aligned JR.
- Reset mid-operation: everything returns to reset values immediately. The first post-reset edge with stall=0 loads next_pc computed from RESET_PC.

Decomposition:
- Package mips_pc_pkg holds:
  - PC_SEQ/PC_BR/PC_J/PC_JR 2-bit localparams.
  - INSTR_BYTES=4.
  - JREGION_LSB=28.
  - A sign-extend-shift function.
- Sub-module ras_stack (params ADDR_W, RAS_DEPTH) owns:
  - Entries, pointer and count.
  - push/pop/replace logic.
  - top and empty outputs.
- next_pc_unit owns the PC register, next-PC mux, alignment check and the registered flags.

Test Plan:
- Reset then 3 cycles SEQ, stall=0 -> pc = 0x0, 0x4, 0x8, 0xC; ras_empty=1.
- pc=0x100, BR, taken, imm16=0xFFFE -> pc=0x0FC. Same with not-taken -> pc=0x104.
- pc=0x4000_0010, J, jidx=0x0000040 -> pc=0x4000_0100. pc=0xFFFF_FFFC, SEQ -> pc=0x0 (wrap).
- jal at pc=0x20 (J, link=1) -> ras_top=0x24. Later JR ret=1, rs_val=0x24 -> pc=0x24, ras_mismatch=0, ras_empty=1. Repeat with rs_val=0x28 -> ras_mismatch pulses 1, pc=0x28.
- RAS_DEPTH=4: 5 pushes (0x04..0x14) then 5 pops -> tops 0x14, 0x10, 0x0C, 0x08. The fifth pop hits an empty RAS -> ras_mismatch=1.
- JR rs_val=0x102 -> pc holds, addr_err=1 for one cycle. stall=1 during BR -> pc unchanged. rst_n pulsed low mid-sequence -> pc=RESET_PC asynchronously.

Source files
------------

// File: rtl/mips_pc_pkg.sv
// Shared encodings and helpers for the fetch-path next-PC logic.
// Select codes, instruction geometry and the branch-offset helper.
package mips_pc_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_J   = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

  localparam int INSTR_BYTES = 4;
  localparam int JREGION_LSB = 28;
  localparam int BR_OFF_W    = 18;

  // Word offset to byte offset; the caller sign-extends from bit 17 to the PC width.
  function automatic logic [BR_OFF_W-1:0] sext_shift2(input logic [15:0] imm);
    return {imm, 2'b00};
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push, pop and in-place replace of the top entry.
// When full, a push silently overwrites the oldest entry.
module ras_stack
  import mips_pc_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] entries_r [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  top_ptr_s;
  logic [CNT_W-1:0]  count_r;
  logic              empty_s;

  assign top_ptr_s = wr_ptr_r - PTR_W'(1);
  assign empty_s   = (count_r == CNT_W'(0));
  assign empty     = empty_s;
  assign top       = empty_s ? {ADDR_W{1'b0}} : entries_r[top_ptr_s];

  // Stack storage, write pointer and occupancy; push+pop on a non-empty stack replaces the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        entries_r[i] <= {ADDR_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (push && pop && !empty_s) begin
      entries_r[top_ptr_s] <= push_data;
    end else if (push) begin
      entries_r[wr_ptr_r] <= push_data;
      wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
      if (count_r != CNT_FULL) begin
        count_r <= count_r + CNT_W'(1);
      end
    end else if (pop && !empty_s) begin
      wr_ptr_r <= top_ptr_s;
      count_r  <= count_r - CNT_W'(1);
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Architectural PC register with next-PC selection for SEQ/BR/J/JR flow,
// plus a return-address stack that checks jr return predictions.
module next_pc_unit
  import mips_pc_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [1:0]        pc_sel,
  input  logic              branch_taken,
  input  logic [15:0]       imm16,
  input  logic [25:0]       jidx,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic              link,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] link_addr,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_empty,
  output logic              ras_mismatch,
  output logic              addr_err
);

  localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0]   pc_r;
  logic [ADDR_W-1:0]   pc_plus4_s;
  logic [BR_OFF_W-1:0] br_off_s;
  logic [ADDR_W-1:0]   br_target_s;
  logic [ADDR_W-1:0]   j_target_s;
  logic [ADDR_W-1:0]   next_pc_s;
  logic                jr_misaligned_s;
  logic                jr_ok_s;
  logic                push_s;
  logic                pop_s;
  logic                mismatch_nxt_s;
  logic                addr_err_nxt_s;
  logic                ras_mismatch_r;
  logic                addr_err_r;
  logic [ADDR_W-1:0]   ras_top_s;
  logic                ras_empty_s;

  assign pc_plus4_s  = pc_r + ADDR_W'(INSTR_BYTES);
  assign br_off_s    = sext_shift2(imm16);
  assign br_target_s = pc_plus4_s + {{(ADDR_W-BR_OFF_W){br_off_s[BR_OFF_W-1]}}, br_off_s};

  // Jumps stay inside the 256 MB region of the delay-slot address.
  generate
    if (ADDR_W > JREGION_LSB) begin : g_jregion
      assign j_target_s = {pc_plus4_s[ADDR_W-1:JREGION_LSB], jidx, 2'b00};
    end else begin : g_jflat
      assign j_target_s = {jidx, 2'b00};
    end
  endgenerate

  assign jr_misaligned_s = (pc_sel == PC_JR) && (rs_val[1:0] != 2'b00);
  assign jr_ok_s         = (pc_sel == PC_JR) && !jr_misaligned_s;

  // Next-PC mux; a misaligned JR target holds the current PC.
  always_comb begin
    next_pc_s = pc_plus4_s;
    case (pc_sel)
      PC_SEQ: next_pc_s = pc_plus4_s;
      PC_BR: begin
        if (branch_taken) begin
          next_pc_s = br_target_s;
        end else begin
          next_pc_s = pc_plus4_s;
        end
      end
      PC_J: next_pc_s = j_target_s;
      PC_JR: begin
        if (jr_misaligned_s) begin
          next_pc_s = pc_r;
        end else begin
          next_pc_s = rs_val;
        end
      end
      default: next_pc_s = pc_plus4_s;
    endcase
  end

  // RAS control and flag next-state; the compare always uses the pre-update top.
  always_comb begin
    push_s         = !stall && link && ((pc_sel == PC_J) || jr_ok_s);
    pop_s          = !stall && ret && jr_ok_s;
    mismatch_nxt_s = pop_s && (ras_empty_s || (rs_val != ras_top_s));
    addr_err_nxt_s = !stall && jr_misaligned_s;
  end

  ras_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_s),
    .pop      (pop_s),
    .push_data(pc_plus4_s),
    .top      (ras_top_s),
    .empty    (ras_empty_s)
  );

  // PC register and one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r           <= RESET_PC_W;
      ras_mismatch_r <= 1'b0;
      addr_err_r     <= 1'b0;
    end else begin
      ras_mismatch_r <= mismatch_nxt_s;
      addr_err_r     <= addr_err_nxt_s;
      if (!stall) begin
        pc_r <= next_pc_s;
      end
    end
  end

  assign pc           = pc_r;
  assign pc_plus4     = pc_plus4_s;
  assign link_addr    = pc_plus4_s;
  assign ras_top      = ras_top_s;
  assign ras_empty    = ras_empty_s;
  assign ras_mismatch = ras_mismatch_r;
  assign addr_err     = addr_err_r;

endmodule
